midi_uart_rx: RTL and testbench

Serial MIDI receiver at the front of the synthesizer. Deserializes the 31 250 baud MIDI line (8N1, LSB first) into bytes and presents each one as `data_out` with a single-cycle `data_out_ready` strobe. These outputs connect directly to the top level's `data_in` / `data_in_ready`, which feed the MIDI decoder. Also flags framing errors for debug display.

---
 rtl/midi_uart_rx_pkg.sv | 26 ++
 rtl/midi_uart_rx_sync.sv | 32 +++
 rtl/midi_uart_rx.sv | 175 +++++++++++++++++
 tb/tb_midi_uart_rx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/midi_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// Shared packages for the MIDI receive path.
//
//   CONFIG : system-wide constants (byte width, system clock, MIDI bit rate).
//   MIDI   : receiver FSM state type and the 3-input majority helper used
//            when MIDI_RX_MAJORITY_EN is defined.
// ---------------------------------------------------------------------------
package CONFIG;
    localparam int BYTE_WIDTH = 8;
    localparam int CLOCK_HZ   = 50_000_000;
    localparam int MIDI_BAUD  = 31_250;
endpackage

package MIDI;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/midi_uart_rx_sync.sv
// ---------------------------------------------------------------------------
// Synchronizer: DEPTH-flop synchronizer for an asynchronous single-bit input.
// All flops reset to RESET_VALUE so a line that idles at that level does not
// produce a spurious edge when reset releases. DEPTH must be at least 2.
//
// Ports:
//   i_clk    in  1  clock, rising edge
//   i_reset  in  1  synchronous, active-high reset
//   i_async  in  1  asynchronous input
//   o_sync   out 1  synchronized copy of i_async (DEPTH cycles of latency)
// ---------------------------------------------------------------------------
module Synchronizer #(
    parameter int   DEPTH       = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);
    logic [DEPTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= {DEPTH{RESET_VALUE}};
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_async};
        end
    end

    assign o_sync = r_sync[DEPTH-1];
endmodule

// File: rtl/midi_uart_rx.sv
// ---------------------------------------------------------------------------
// midi_uart_rx: 8N1, LSB-first MIDI serial receiver.
//
// Deserializes midi_rx into bytes. Each good byte is presented on data_out
// with a one-cycle data_out_ready pulse; data_out then holds until the next
// good byte. A low stop bit gives a one-cycle framing_error pulse instead,
// and the receiver waits for the line to return high before rearming.
//
// Ports:
//   clock_50_000_000  in  1           system clock, rising edge
//   reset             in  1           synchronous, active-high reset
//   midi_rx           in  1           raw asynchronous serial line (idle high)
//   data_out          out BYTE_WIDTH  last good byte
//   data_out_ready    out 1           one-cycle strobe, data_out valid
//   framing_error     out 1           one-cycle strobe, stop bit was low
//
// Build option:
//   MIDI_RX_MAJORITY_EN  when defined, each bit decision is the majority of
//                        three consecutive synchronized samples instead of
//                        a single sample.
// ---------------------------------------------------------------------------
module midi_uart_rx
    import MIDI::*;
#(
    parameter int CLOCK_HZ     = CONFIG::CLOCK_HZ,
    parameter int BAUD         = CONFIG::MIDI_BAUD,
    parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD
) (
    input  logic                         clock_50_000_000,
    input  logic                         reset,
    input  logic                         midi_rx,
    output logic [CONFIG::BYTE_WIDTH-1:0] data_out,
    output logic                         data_out_ready,
    output logic                         framing_error
);
    localparam int BW    = CONFIG::BYTE_WIDTH;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(BW - 1);

    logic              w_rx_s;
    logic              w_sample;

    uart_state_t       r_state,  w_state_nx;
    logic [CNT_W-1:0]  r_count,  w_count_nx;
    logic [2:0]        r_idx,    w_idx_nx;
    logic [BW-1:0]     r_shift,  w_shift_nx;
    logic [BW-1:0]     r_data,   w_data_nx;
    logic              r_ready,  w_ready_nx;
    logic              r_ferr,   w_ferr_nx;

    Synchronizer #(
        .DEPTH       (2),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .i_clk   (clock_50_000_000),
        .i_reset (reset),
        .i_async (midi_rx),
        .o_sync  (w_rx_s)
    );

`ifdef MIDI_RX_MAJORITY_EN
    // The vote window ends on the nominal sample cycle, so the decision and
    // the output pulses keep exactly the same timing as the single-sample
    // build; only the two preceding samples are added to the vote.
    logic [1:0] r_hist;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_hist <= '1;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_sample = maj3(r_hist[1], r_hist[0], w_rx_s);
`else
    assign w_sample = w_rx_s;
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_count <= w_count_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_data  <= w_data_nx;
            r_ready <= w_ready_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count + 1'b1;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_data_nx  = r_data;
        w_ready_nx = 1'b0;
        w_ferr_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                w_count_nx = '0;
                if (!w_rx_s) begin
                    w_state_nx = START;
                end
            end

            START: begin
                if (r_count == HALF_LAST) begin
                    if (!w_sample) begin
                        w_count_nx = '0;
                        w_idx_nx   = '0;
                        w_state_nx = DATA;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end

            DATA: begin
                if (r_count == BIT_LAST) begin
                    w_count_nx         = '0;
                    w_shift_nx[r_idx]  = w_sample;
                    w_idx_nx           = r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = STOP;
                    end
                end
            end

            // Leaving at the stop-bit midpoint lets the next start edge,
            // which may arrive in the second half of the stop bit, be seen.
            STOP: begin
                if (r_count == BIT_LAST) begin
                    w_count_nx = '0;
                    if (w_sample) begin
                        w_data_nx  = r_shift;
                        w_ready_nx = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_ferr_nx  = 1'b1;
                        w_state_nx = WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                w_count_nx = '0;
                if (w_rx_s) begin
                    w_state_nx = IDLE;
                end
            end

            default: begin
                w_count_nx = '0;
                w_state_nx = IDLE;
            end
        endcase
    end

    assign data_out       = r_data;
    assign data_out_ready = r_ready;
    assign framing_error  = r_ferr;
endmodule

// File: tb/tb_midi_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_midi_uart_rx: scoreboard bench for midi_uart_rx.
//
// The DUT runs with a short bit period (CLKS_PER_BIT = C) so the whole
// directed sequence stays small. Each frame the stimulus sends pushes the
// event it should produce (ready or framing error, expected data_out, and the
// exact cycle of the pulse) into a queue; a monitor on the falling edge pops
// and compares whenever the DUT raises a strobe.
// ---------------------------------------------------------------------------
module tb_midi_uart_rx;
    import MIDI::*;

    localparam int C   = 16;
    // Line drops in cycle s; rx_s low from s+2 (=t); pulse visible at t+9.5C+1.
    localparam int LAT = (19 * C) / 2 + 3;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       midi_rx = 1'b1;
    logic [7:0] data_out;
    logic       data_out_ready;
    logic       framing_error;

    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  last_byte = 8'h00;

    typedef struct {
        bit          is_err;
        logic [7:0]  val;
        int unsigned when;
    } exp_t;

    exp_t q[$];

    midi_uart_rx #(
        .CLKS_PER_BIT (C)
    ) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .midi_rx          (midi_rx),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .framing_error    (framing_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20000 * 10);
        $display("FAIL watchdog: simulation still running at cycle %0d, required to finish earlier", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every strobe must match the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && (data_out_ready || framing_error)) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_event: ready=%0b ferr=%0b data=0x%02h at cycle %0d, expected no event",
                         data_out_ready, framing_error, data_out, cyc);
            end else begin
                e = q.pop_front();
                check("ferr_strobe", 32'(framing_error), 32'(e.is_err));
                check("ready_strobe", 32'(data_out_ready), 32'(!e.is_err));
                check("data_out", 32'(data_out), 32'(e.val));
                check("event_cycle", cyc, e.when);
            end
        end
    end

    task automatic reset_outputs_check();
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_ready", 32'(data_out_ready), 32'h0);
        check("reset_ferr", 32'(framing_error), 32'h0);
    endtask

    // Must be entered 1 time unit after a rising edge; returns aligned the same way.
    // glitch_at: frame cycle whose level is inverted (-1 none).
    // rst_at:    frame cycle at which reset interrupts the frame (-1 none).
    // hold_low:  extra low cycles after the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic [7:0] want_b,
                              input logic stop_lvl, input int glitch_at,
                              input int rst_at, input int hold_low);
        int unsigned s;
        int          bitpos;
        logic        lvl;
        exp_t        e;
        s = cyc;
        if (rst_at < 0) begin
            e.is_err = !stop_lvl;
            e.val    = stop_lvl ? want_b : last_byte;
            e.when   = s + LAT;
            q.push_back(e);
            if (stop_lvl) last_byte = want_b;
        end
        for (int i = 0; i < 10 * C; i++) begin
            if (i == rst_at) begin
                reset   = 1'b1;
                midi_rx = 1'b1;
                @(posedge clk);
                repeat (3) begin
                    @(negedge clk);
                    reset_outputs_check();
                end
                @(posedge clk);
                #1;
                reset     = 1'b0;
                last_byte = 8'h00;
                return;
            end
            bitpos = i / C;
            if (bitpos == 0)      lvl = 1'b0;
            else if (bitpos <= 8) lvl = b[bitpos-1];
            else                  lvl = stop_lvl;
            if (i == glitch_at) lvl = ~lvl;
            midi_rx = lvl;
            tick(1);
        end
        if (hold_low > 0) begin
            midi_rx = 1'b0;
            tick(hold_low);
        end
        midi_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] maj_want;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_outputs_check();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(2 * C);

        // Single byte
        send_frame(8'h90, 8'h90, 1'b1, -1, -1, 0);
        tick(2 * C);

        // Back-to-back, no idle between frames: pulses exactly 10*C apart
        send_frame(8'h90, 8'h90, 1'b1, -1, -1, 0);
        send_frame(8'h3C, 8'h3C, 1'b1, -1, -1, 0);
        send_frame(8'h7F, 8'h7F, 1'b1, -1, -1, 0);
        tick(2 * C);

        // Quarter-bit low glitch on an idle line is a false start
        midi_rx = 1'b0;
        tick(C / 4);
        midi_rx = 1'b1;
        tick(2 * C);
        check("fsm_idle_after_false_start", 32'(dut.r_state), 32'(IDLE));
        send_frame(8'h55, 8'h55, 1'b1, -1, -1, 0);
        tick(2 * C);

        // Low stop bit then a held break: framing error, data_out unchanged
        send_frame(8'hA5, 8'hA5, 1'b0, -1, -1, 5 * C);
        tick(2 * C);
        send_frame(8'h12, 8'h12, 1'b1, -1, -1, 0);
        tick(2 * C);

        // Reset during data bit 4 discards the frame
        send_frame(8'hFF, 8'hFF, 1'b1, -1, 5 * C, 0);
        tick(2 * C);
        send_frame(8'h01, 8'h01, 1'b1, -1, -1, 0);
        tick(2 * C);

        // One-cycle high pulse landing on the bit-3 sample point
`ifdef MIDI_RX_MAJORITY_EN
        maj_want = 8'h00;
`else
        maj_want = 8'h08;
`endif
        send_frame(8'h00, maj_want, 1'b1, C / 2 + 4 * C, -1, 0);
        tick(3 * C);

        check("pending_expected_events", 32'(q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
